// File: rtl/ff_adc_seq.sv
// ADC0809-style start/convert/EOC sequencer for the Food Fight analog joystick path.
// Samples the two signed axes on js_analog, conditions the selected one and holds the result.
module ff_adc_seq #(
    parameter int          CONV_CYCLES = 1200,
    parameter logic [7:0]  IDLE_VAL    = 8'h80,
    parameter bit          INV_X       = 1'b0,
    parameter bit          INV_Y       = 1'b0,
    parameter logic [7:0]  DEADZONE    = 8'd0
) (
    input  logic        clk_12mhz,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ch_sel,
    input  logic [15:0] js_analog,
    output logic [7:0]  adc_data,
    output logic        eoc,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a one-cycle start strobe always wins (IDLE, mid-conversion or on the
    // completing edge); eoc=1 means adc_data is valid and stable, eoc=0 means a
    // conversion is in flight and adc_data still holds the previous result.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2
    } state_t;

    localparam logic [10:0] CNT_LOAD = 11'(CONV_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_ch;
    logic [1:0]  r_retry;
    logic [10:0] r_cnt;
    logic [7:0]  r_val;
    logic [7:0]  r_data;
    logic        r_eoc;
    logic [15:0] r_s1;
    logic [15:0] r_s2;

    state_t      w_state_nx;
    logic [1:0]  w_ch_nx;
    logic [1:0]  w_retry_nx;
    logic [10:0] w_cnt_nx;
    logic [7:0]  w_val_nx;
    logic [7:0]  w_data_nx;
    logic        w_eoc_nx;

    logic [7:0]  w_raw;
    logic        w_inv_en;
    logic [7:0]  w_inv;
    logic [7:0]  w_mag;
    logic [7:0]  w_dz;
    logic [7:0]  w_cond;

    // Two-flop capture of the asynchronous bus; free running, not reset.
    always_ff @(posedge clk_12mhz) begin
        r_s1 <= js_analog;
        r_s2 <= r_s1;
    end

    // Conditioning: invert (saturating -128), dead zone, then signed -> offset binary.
    always_comb begin
        w_raw    = r_ch[0] ? r_s1[15:8] : r_s1[7:0];
        w_inv_en = r_ch[0] ? INV_Y : INV_X;
        w_inv    = w_raw;
        if (w_inv_en) begin
            w_inv = (w_raw == 8'h80) ? 8'h7F : (~w_raw + 8'd1);
        end
        w_mag = w_inv[7] ? (~w_inv + 8'd1) : w_inv;
        w_dz  = (w_mag < DEADZONE) ? 8'h00 : w_inv;
        w_cond = w_dz ^ 8'h80;
    end

    always_comb begin
        w_state_nx = r_state;
        w_ch_nx    = r_ch;
        w_retry_nx = r_retry;
        w_cnt_nx   = r_cnt;
        w_val_nx   = r_val;
        w_data_nx  = r_data;
        w_eoc_nx   = r_eoc;
        case (r_state)
            S_IDLE: begin
            end
            S_SAMPLE: begin
                if (r_ch[1] || (r_s1 == r_s2) || (r_retry == 2'd3)) begin
                    w_val_nx   = r_ch[1] ? IDLE_VAL : w_cond;
                    w_cnt_nx   = CNT_LOAD;
                    w_state_nx = S_CONVERT;
                end else begin
                    w_retry_nx = r_retry + 2'd1;
                end
            end
            S_CONVERT: begin
                if (r_cnt == 11'd0) begin
                    w_data_nx  = r_val;
                    w_eoc_nx   = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 11'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        // A start applies after any completion on the same edge, so that write survives.
        if (start) begin
            w_state_nx = S_SAMPLE;
            w_ch_nx    = ch_sel;
            w_retry_nx = 2'd0;
            w_eoc_nx   = 1'b0;
        end
    end

    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ch    <= 2'd0;
            r_retry <= 2'd0;
            r_cnt   <= 11'd0;
            r_val   <= IDLE_VAL;
            r_data  <= IDLE_VAL;
            r_eoc   <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_ch    <= w_ch_nx;
            r_retry <= w_retry_nx;
            r_cnt   <= w_cnt_nx;
            r_val   <= w_val_nx;
            r_data  <= w_data_nx;
            r_eoc   <= w_eoc_nx;
        end
    end

    assign adc_data  = r_data;
    assign eoc       = r_eoc;
    assign busy      = ~r_eoc;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ff_adc_seq.sv
// Self-checking bench for ff_adc_seq: three parameter variants share one stimulus stream
// and are compared every cycle against a conversion-level model plus literal expectations.
module tb_ff_adc_seq;

  localparam int CONV = 8;

  logic        clk_12mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic [1:0]  ch_sel    = 2'd0;
  logic [15:0] js_analog = 16'h0000;

  logic [7:0]  dut_data[3];
  logic        dut_eoc[3];
  logic        dut_busy[3];
  logic [1:0]  dut_state[3];

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // clock / reset block
  always #5 clk_12mhz = ~clk_12mhz;

  ff_adc_seq #(.CONV_CYCLES(CONV), .IDLE_VAL(8'h80), .INV_X(1'b0), .INV_Y(1'b0), .DEADZONE(8'd0)) dut_a (
    .clk_12mhz(clk_12mhz), .reset(reset), .start(start), .ch_sel(ch_sel), .js_analog(js_analog),
    .adc_data(dut_data[0]), .eoc(dut_eoc[0]), .busy(dut_busy[0]), .dbg_state(dut_state[0]));

  ff_adc_seq #(.CONV_CYCLES(CONV), .IDLE_VAL(8'h80), .INV_X(1'b1), .INV_Y(1'b1), .DEADZONE(8'd0)) dut_b (
    .clk_12mhz(clk_12mhz), .reset(reset), .start(start), .ch_sel(ch_sel), .js_analog(js_analog),
    .adc_data(dut_data[1]), .eoc(dut_eoc[1]), .busy(dut_busy[1]), .dbg_state(dut_state[1]));

  ff_adc_seq #(.CONV_CYCLES(CONV), .IDLE_VAL(8'h80), .INV_X(1'b0), .INV_Y(1'b0), .DEADZONE(8'd8)) dut_c (
    .clk_12mhz(clk_12mhz), .reset(reset), .start(start), .ch_sel(ch_sel), .js_analog(js_analog),
    .adc_data(dut_data[2]), .eoc(dut_eoc[2]), .busy(dut_busy[2]), .dbg_state(dut_state[2]));

  // model configuration per instance
  bit inv_x_cfg[3] = '{1'b0, 1'b1, 1'b0};
  bit inv_y_cfg[3] = '{1'b0, 1'b1, 1'b0};
  int dz_cfg[3]    = '{0, 0, 8};

  // model: one record per conversion in flight, timed by edge numbers
  int          edge_n = 0;
  logic [15:0] hist[0:1023];
  bit          m_act;
  int          m_k;
  logic [1:0]  m_ch;
  int          m_done;
  logic [7:0]  m_val[3];
  logic [7:0]  m_data[3];

  function automatic logic [7:0] cond(input logic [7:0] raw, input bit inv, input int dz);
    int s;
    int mag;
    s = int'($signed(raw));
    if (inv) s = (s == -128) ? 127 : -s;
    mag = (s < 0) ? -s : s;
    if (mag < dz) s = 0;
    return 8'(s + 128);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) hist[i] = 16'h0000;
    m_act = 1'b0; m_k = 0; m_ch = 2'd0; m_done = -1;
    for (int i = 0; i < 3; i++) begin m_val[i] = 8'h80; m_data[i] = 8'h80; end
  end

  always @(posedge clk_12mhz) begin
    logic [15:0] s1v;
    logic [15:0] s2v;
    edge_n = edge_n + 1;
    hist[edge_n & 1023] = js_analog;
    s1v = hist[(edge_n - 1) & 1023];
    s2v = hist[(edge_n - 2) & 1023];
    if (reset) begin
      m_act = 1'b0; m_done = -1;
      for (int i = 0; i < 3; i++) m_data[i] = 8'h80;
    end else begin
      if (m_act && m_done >= 0 && edge_n == m_done) begin
        for (int i = 0; i < 3; i++) m_data[i] = m_val[i];
        m_act = 1'b0;
      end
      if (start) begin
        m_act = 1'b1; m_k = edge_n; m_ch = ch_sel; m_done = -1;
      end else if (m_act && m_done < 0) begin
        if (m_ch[1] || s1v == s2v || (edge_n - 1 - m_k) == 3) begin
          for (int i = 0; i < 3; i++) begin
            if (m_ch[1]) m_val[i] = 8'h80;
            else if (m_ch == 2'd0) m_val[i] = cond(s1v[7:0], inv_x_cfg[i], dz_cfg[i]);
            else m_val[i] = cond(s1v[15:8], inv_y_cfg[i], dz_cfg[i]);
          end
          m_done = edge_n + CONV;
        end
      end
    end
  end

  // scoreboard: per-cycle compare against the model
  always @(negedge clk_12mhz) begin
    logic [1:0] exp_st;
    if (chk_en && !reset) begin
      exp_st = !m_act ? 2'd0 : (m_done < 0 ? 2'd1 : 2'd2);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dut_data[i] !== m_data[i] || dut_eoc[i] !== !m_act || dut_busy[i] !== m_act ||
            dut_state[i] !== exp_st)
          $display("FAIL model_cmp inst%0d t=%0t: data=%h eoc=%b busy=%b st=%0d, required data=%h eoc=%b busy=%b st=%0d",
                   i, $time, dut_data[i], dut_eoc[i], dut_busy[i], dut_state[i],
                   m_data[i], !m_act, m_act, exp_st);
        else passes++;
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_12mhz);
      @(negedge clk_12mhz);
    end
  endtask

  task automatic pulse_start(input logic [1:0] ch);
    start = 1'b1; ch_sel = ch;
    cyc(1);
    start = 1'b0; ch_sel = $urandom_range(0, 3);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
    else passes++;
  endtask

  task automatic convert_stable(input logic [15:0] js, input logic [1:0] ch);
    js_analog = js;
    cyc(3);
    pulse_start(ch);
    cyc(CONV + 2);
  endtask

  initial begin
    // 1: reset state and idle hold
    cyc(3);
    reset = 1'b0;
    chk_en = 1'b1;
    cyc(1);
    chk("rst_data", dut_data[0], 8'h80);
    chk("rst_eoc", {7'd0, dut_eoc[0]}, 8'd1);
    chk("rst_busy", {7'd0, dut_busy[0]}, 8'd0);
    js_analog = 16'h3FC0;
    cyc(5);
    chk("idle_hold", dut_data[0], 8'h80);

    // 2: basic latency and both axes
    js_analog = 16'h40C0;
    cyc(3);
    pulse_start(2'd0);
    chk("lat_k_busy", {7'd0, dut_busy[0]}, 8'd1);
    cyc(CONV);
    chk("lat_k8_busy", {7'd0, dut_busy[0]}, 8'd1);
    chk("lat_k8_hold", dut_data[0], 8'h80);
    cyc(1);
    chk("lat_k9_eoc", {7'd0, dut_eoc[0]}, 8'd1);
    chk("x_40", dut_data[0], 8'h40);
    convert_stable(16'h40C0, 2'd1);
    chk("y_c0", dut_data[0], 8'hC0);

    // 3: inversion and dead zone
    convert_stable(16'h0080, 2'd0);
    chk("inv_m128", dut_data[1], 8'hFF);
    convert_stable(16'h0005, 2'd0);
    chk("inv_05", dut_data[1], 8'h7B);
    chk("dz_05", dut_data[2], 8'h80);
    convert_stable(16'h00F8, 2'd0);
    chk("dz_f8", dut_data[2], 8'h78);

    // 4: unstable input -> four sample cycles
    js_analog = 16'h1122; cyc(1);
    js_analog = 16'h3344; cyc(1);
    js_analog = 16'h1122;
    start = 1'b1; ch_sel = 2'd0; cyc(1); start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      js_analog = (i % 2 == 1) ? 16'h3344 : 16'h1122;
      cyc(1);
    end
    chk("tog_k11_eoc", {7'd0, dut_eoc[0]}, 8'd0);
    cyc(1);
    chk("tog_k12_eoc", {7'd0, dut_eoc[0]}, 8'd1);
    chk("tog_val", dut_data[0], 8'hC4);

    // 5: abort and restart
    js_analog = 16'h7F81;
    cyc(3);
    pulse_start(2'd0);
    cyc(3);
    pulse_start(2'd1);
    cyc(8);
    chk("abort_k12_eoc", {7'd0, dut_eoc[0]}, 8'd0);
    cyc(1);
    chk("abort_k13_eoc", {7'd0, dut_eoc[0]}, 8'd1);
    chk("abort_y", dut_data[0], 8'hFF);

    // 6: reset mid-conversion
    js_analog = 16'h0011;
    cyc(3);
    pulse_start(2'd0);
    cyc(4);
    reset = 1'b1;
    #1;
    chk("arst_eoc", {7'd0, dut_eoc[0]}, 8'd1);
    chk("arst_busy", {7'd0, dut_busy[0]}, 8'd0);
    chk("arst_data", dut_data[0], 8'h80);
    @(negedge clk_12mhz);
    cyc(1);
    reset = 1'b0;
    convert_stable(16'h0011, 2'd0);
    chk("post_rst", dut_data[0], 8'h91);

    // 5b: idle channel ignores the bus
    convert_stable(16'h5A5A, 2'd2);
    chk("ch2_idle", dut_data[0], 8'h80);

    // randomized phase, including completion-edge and mid-conversion starts
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) js_analog = 16'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        start = 1'b1; ch_sel = $urandom_range(0, 3);
      end else begin
        start = 1'b0; ch_sel = $urandom_range(0, 3);
      end
      cyc(1);
    end
    start = 1'b0;
    cyc(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
